// File: rtl/led_panel_scanner_pkg.sv
// Shared types and constants for the LED panel scanner.
// Holds the scan FSM states, the pixel channel offsets inside a BRAM word,
// and a helper that picks one bit-plane bit out of an 8-bit channel.
package led_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RD_TOP,
        RD_BOT,
        SHIFT_LO,
        SHIFT_HI,
        BLANK,
        LATCH,
        DISPLAY
    } state_t;

    localparam int R_LSB = 0;
    localparam int G_LSB = 8;
    localparam int B_LSB = 16;

    // Selects bit 'plane' of an 8-bit colour channel.
    function automatic logic plane_bit(input logic [7:0] chan, input logic [2:0] plane);
        return chan[plane];
    endfunction

endpackage

// File: rtl/led_panel_scanner_bcm_timer.sv
// BCM display-window timer.
// Loaded during LATCH with the window length BASE_TICKS<<plane and counts it
// down while the scanner sits in DISPLAY. 'last' marks the final display
// cycle; 'oe_off' tells the scanner whether the next display cycle must be
// blanked. With LED_PANEL_SCANNER_BRIGHTNESS_EN defined, a second counter
// holds the on-time ((window*brightness)>>8) so the LEDs go dark early while
// the window length itself stays unchanged.
module bcm_timer
    import led_pkg::*;
#(
    parameter int BIT_DEPTH  = 8,
    parameter int BASE_TICKS = 4,
    parameter int PLANE_W    = 3,
    parameter int CNT_W      = $clog2(BASE_TICKS << (BIT_DEPTH - 1)) + 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic               run,
    input  logic [PLANE_W-1:0] plane,
`ifdef LED_PANEL_SCANNER_BRIGHTNESS_EN
    input  logic [7:0]         brightness,
`endif
    output logic               last,
    output logic               oe_off
);

    logic [CNT_W-1:0] win;
    logic [CNT_W-1:0] cnt;

    assign win  = CNT_W'(BASE_TICKS) << plane;
    assign last = (cnt == CNT_W'(1));

    // Window counter: load at LATCH, count down through DISPLAY.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= win;
        end else if (run && cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

`ifdef LED_PANEL_SCANNER_BRIGHTNESS_EN
    logic [CNT_W+7:0] prod;
    logic [CNT_W-1:0] thr;
    logic [CNT_W-1:0] on_left;

    assign prod = (CNT_W + 8)'(win) * (CNT_W + 8)'(brightness);
    assign thr  = prod[CNT_W+7:8];

    // On-time counter: brightness is sampled only when the window is loaded.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            on_left <= '0;
        end else if (load) begin
            on_left <= thr;
        end else if (run && on_left != '0) begin
            on_left <= on_left - 1'b1;
        end
    end

    // At load the first display cycle is dark only for a zero on-time;
    // afterwards the next cycle is dark once at most one on-cycle remains.
    assign oe_off = load ? (thr == '0) : (on_left <= CNT_W'(1));
`else
    assign oe_off = 1'b0;
`endif

endmodule

// File: rtl/led_panel_scanner.sv
// HUB75 LED panel scanner fed from the frame-buffer BRAM read port.
// Walks rows and BCM bit-planes: for every column it reads the top and
// bottom pixel, shifts one bit of each channel out, then blanks, latches
// and lights the row for BASE_TICKS<<plane cycles.
// Optional feature macro: LED_PANEL_SCANNER_BRIGHTNESS_EN (adds the
// 8-bit 'brightness' input that shortens the on-time inside each window).
//
// BRAM read interface: fixed latency, no backpressure. When b_en is high
// in a cycle, b_dout carries mem[b_addr] during the following cycle.
module led_panel_scanner
    import led_pkg::*;
#(
    parameter int COL_BITS   = 6,
    parameter int ROW_BITS   = 4,
    parameter int BIT_DEPTH  = 8,
    parameter int BASE_TICKS = 4,
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 1 + ROW_BITS + COL_BITS
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
`ifdef LED_PANEL_SCANNER_BRIGHTNESS_EN
    input  logic [7:0]            brightness,
`endif
    output logic                  b_en,
    output logic [ADDR_WIDTH-1:0] b_addr,
    input  logic [DATA_WIDTH-1:0] b_dout,
    output logic                  panel_r0,
    output logic                  panel_g0,
    output logic                  panel_b0,
    output logic                  panel_r1,
    output logic                  panel_g1,
    output logic                  panel_b1,
    output logic [ROW_BITS-1:0]   panel_a,
    output logic                  panel_clk,
    output logic                  panel_lat,
    output logic                  panel_oe,
    output logic                  frame_done
);

    localparam int PLANE_W = (BIT_DEPTH > 1) ? $clog2(BIT_DEPTH) : 1;

    state_t                state;
    logic [ROW_BITS-1:0]   row;
    logic [COL_BITS-1:0]   col;
    logic [PLANE_W-1:0]    plane;
    logic                  tmr_last;
    logic                  tmr_oe_off;
    logic [2:0]            pidx;
    logic                  unused_dout;

    assign pidx        = 3'(plane);
    assign unused_dout = &{1'b0, b_dout[DATA_WIDTH-1:24]};

    bcm_timer #(
        .BIT_DEPTH (BIT_DEPTH),
        .BASE_TICKS(BASE_TICKS),
        .PLANE_W   (PLANE_W)
    ) u_timer (
        .clk       (clk),
        .rst       (rst),
        .load      (state == LATCH),
        .run       (state == DISPLAY),
        .plane     (plane),
`ifdef LED_PANEL_SCANNER_BRIGHTNESS_EN
        .brightness(brightness),
`endif
        .last      (tmr_last),
        .oe_off    (tmr_oe_off)
    );

    // Scan FSM; every output is registered with the value of the state being entered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            row        <= '0;
            col        <= '0;
            plane      <= '0;
            b_en       <= 1'b0;
            b_addr     <= '0;
            panel_r0   <= 1'b0;
            panel_g0   <= 1'b0;
            panel_b0   <= 1'b0;
            panel_r1   <= 1'b0;
            panel_g1   <= 1'b0;
            panel_b1   <= 1'b0;
            panel_a    <= '0;
            panel_clk  <= 1'b0;
            panel_lat  <= 1'b0;
            panel_oe   <= 1'b1;
            frame_done <= 1'b0;
        end else begin
            b_en       <= 1'b0;
            panel_clk  <= 1'b0;
            panel_lat  <= 1'b0;
            panel_oe   <= 1'b1;
            frame_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (enable) begin
                        state  <= RD_TOP;
                        b_en   <= 1'b1;
                        b_addr <= ADDR_WIDTH'({1'b0, row, col});
                    end
                end
                RD_TOP: begin
                    state  <= RD_BOT;
                    b_en   <= 1'b1;
                    b_addr <= ADDR_WIDTH'({1'b1, row, col});
                end
                RD_BOT: begin
                    // Top pixel is on b_dout now.
                    state    <= SHIFT_LO;
                    panel_r0 <= plane_bit(b_dout[R_LSB +: 8], pidx);
                    panel_g0 <= plane_bit(b_dout[G_LSB +: 8], pidx);
                    panel_b0 <= plane_bit(b_dout[B_LSB +: 8], pidx);
                end
                SHIFT_LO: begin
                    // Bottom pixel is on b_dout now; panel_clk rises with it.
                    state     <= SHIFT_HI;
                    panel_clk <= 1'b1;
                    panel_r1  <= plane_bit(b_dout[R_LSB +: 8], pidx);
                    panel_g1  <= plane_bit(b_dout[G_LSB +: 8], pidx);
                    panel_b1  <= plane_bit(b_dout[B_LSB +: 8], pidx);
                end
                SHIFT_HI: begin
                    if (&col) begin
                        col     <= '0;
                        state   <= BLANK;
                        panel_a <= row;
                    end else begin
                        col    <= col + 1'b1;
                        state  <= RD_TOP;
                        b_en   <= 1'b1;
                        b_addr <= ADDR_WIDTH'({1'b0, row, col + 1'b1});
                    end
                end
                BLANK: begin
                    state     <= LATCH;
                    panel_lat <= 1'b1;
                end
                LATCH: begin
                    state    <= DISPLAY;
                    panel_oe <= tmr_oe_off;
                end
                DISPLAY: begin
                    if (!tmr_last) begin
                        panel_oe <= tmr_oe_off;
                    end else if (plane != PLANE_W'(BIT_DEPTH - 1)) begin
                        plane  <= plane + 1'b1;
                        state  <= RD_TOP;
                        b_en   <= 1'b1;
                        b_addr <= ADDR_WIDTH'({1'b0, row, col});
                    end else begin
                        plane <= '0;
                        row   <= row + 1'b1;
                        if (&row) begin
                            frame_done <= 1'b1;
                            if (enable) begin
                                state  <= RD_TOP;
                                b_en   <= 1'b1;
                                b_addr <= '0;
                            end else begin
                                state <= IDLE;
                            end
                        end else begin
                            state  <= RD_TOP;
                            b_en   <= 1'b1;
                            b_addr <= ADDR_WIDTH'({1'b0, row + 1'b1, col});
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_led_panel_scanner.sv
// Directed bench for led_panel_scanner on a 4-column, 2-scan-row, 2-plane
// panel with BASE_TICKS=2. A BRAM model answers reads one cycle late.
// Optional feature macro: LED_PANEL_SCANNER_BRIGHTNESS_EN.
module tb_led_panel_scanner;

    localparam int COL_BITS   = 2;
    localparam int ROW_BITS   = 1;
    localparam int BIT_DEPTH  = 2;
    localparam int BASE_TICKS = 2;
    localparam int DATA_WIDTH = 32;
    localparam int ADDR_WIDTH = 4;

`ifdef LED_PANEL_SCANNER_BRIGHTNESS_EN
    // brightness held at 255 for the main tests: on-time = window-1
    localparam int ON0  = 1;
    localparam int ON1  = 3;
    localparam int LOWS = 8;
`else
    localparam int ON0  = 2;
    localparam int ON1  = 4;
    localparam int LOWS = 12;
`endif

    logic                  clk;
    logic                  rst;
    logic                  enable;
`ifdef LED_PANEL_SCANNER_BRIGHTNESS_EN
    logic [7:0]            brightness;
`endif
    logic                  b_en;
    logic [ADDR_WIDTH-1:0] b_addr;
    logic [DATA_WIDTH-1:0] b_dout;
    logic                  panel_r0, panel_g0, panel_b0;
    logic                  panel_r1, panel_g1, panel_b1;
    logic [ROW_BITS-1:0]   panel_a;
    logic                  panel_clk, panel_lat, panel_oe, frame_done;

    logic [31:0] mem [16];
    int n_checks;
    int n_fail;

    led_panel_scanner #(
        .COL_BITS  (COL_BITS),
        .ROW_BITS  (ROW_BITS),
        .BIT_DEPTH (BIT_DEPTH),
        .BASE_TICKS(BASE_TICKS),
        .DATA_WIDTH(DATA_WIDTH),
        .ADDR_WIDTH(ADDR_WIDTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .enable    (enable),
`ifdef LED_PANEL_SCANNER_BRIGHTNESS_EN
        .brightness(brightness),
`endif
        .b_en      (b_en),
        .b_addr    (b_addr),
        .b_dout    (b_dout),
        .panel_r0  (panel_r0),
        .panel_g0  (panel_g0),
        .panel_b0  (panel_b0),
        .panel_r1  (panel_r1),
        .panel_g1  (panel_g1),
        .panel_b1  (panel_b1),
        .panel_a   (panel_a),
        .panel_clk (panel_clk),
        .panel_lat (panel_lat),
        .panel_oe  (panel_oe),
        .frame_done(frame_done)
    );

    // clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // BRAM read port model: one cycle of read latency
    always @(posedge clk) begin
        if (b_en) b_dout <= mem[b_addr];
    end

    function automatic logic bit_of(input logic [31:0] w, input int lsb, input int plane);
        return 1'(w >> (lsb + plane));
    endfunction

    task automatic wait_b_en(input string name);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 8 && !seen; i++) begin
            @(negedge clk);
            if (b_en === 1'b1) seen = 1'b1;
        end
        n_checks++;
        if (!seen || b_addr !== 4'd0) begin
            n_fail++;
            $display("FAIL %s: b_en seen=%0b addr=%0d, required b_en=1 addr=0", name, seen, b_addr);
        end
    endtask

    // Walk one row/plane: 4 columns of reads and shifts, blank, latch, display.
    // Entered and left at the negedge of the first cycle of a column-0 read.
    task automatic test_row_plane(input int row, input int plane, input int on, input logic exp_done);
        logic [31:0] tw, bw;
        logic [6:0]  exp7;
        int          w;
        for (int c = 0; c < 4; c++) begin
            tw = mem[row*4 + c];
            bw = mem[8 + row*4 + c];
            n_checks++;
            if ({b_en, b_addr, panel_oe, panel_lat} !== {1'b1, 4'(row*4 + c), 1'b1, 1'b0}) begin
                n_fail++;
                $display("FAIL rd_top r%0d p%0d c%0d: en=%0b addr=%0d oe=%0b lat=%0b, required 1 %0d 1 0",
                         row, plane, c, b_en, b_addr, panel_oe, panel_lat, row*4 + c);
            end
            @(negedge clk);
            n_checks++;
            if ({b_en, b_addr} !== {1'b1, 4'(8 + row*4 + c)}) begin
                n_fail++;
                $display("FAIL rd_bot r%0d p%0d c%0d: en=%0b addr=%0d, required 1 %0d",
                         row, plane, c, b_en, b_addr, 8 + row*4 + c);
            end
            @(negedge clk);
            exp7 = {1'b0, bit_of(tw, 0, plane), bit_of(tw, 8, plane), bit_of(tw, 16, plane), 3'b000};
            n_checks++;
            if ({b_en, panel_clk, panel_r0, panel_g0, panel_b0, panel_oe} !==
                {1'b0, 1'b0, exp7[5:3], 1'b1}) begin
                n_fail++;
                $display("FAIL shift_lo r%0d p%0d c%0d: en=%0b clk=%0b rgb0=%0b%0b%0b oe=%0b, required 0 0 %03b 1",
                         row, plane, c, b_en, panel_clk, panel_r0, panel_g0, panel_b0, panel_oe, exp7[5:3]);
            end
            @(negedge clk);
            exp7 = {1'b1, bit_of(tw, 0, plane), bit_of(tw, 8, plane), bit_of(tw, 16, plane),
                    bit_of(bw, 0, plane), bit_of(bw, 8, plane), bit_of(bw, 16, plane)};
            n_checks++;
            if ({panel_clk, panel_r0, panel_g0, panel_b0, panel_r1, panel_g1, panel_b1} !== exp7) begin
                n_fail++;
                $display("FAIL shift_hi r%0d p%0d c%0d: clk,rgb0,rgb1=%07b, required %07b", row, plane, c,
                         {panel_clk, panel_r0, panel_g0, panel_b0, panel_r1, panel_g1, panel_b1}, exp7);
            end
            @(negedge clk);
        end
        n_checks++;
        if ({panel_oe, panel_lat, panel_clk, b_en, panel_a} !== {1'b1, 1'b0, 1'b0, 1'b0, 1'(row)}) begin
            n_fail++;
            $display("FAIL blank r%0d p%0d: oe=%0b lat=%0b clk=%0b en=%0b a=%0d, required 1 0 0 0 %0d",
                     row, plane, panel_oe, panel_lat, panel_clk, b_en, panel_a, row);
        end
        @(negedge clk);
        n_checks++;
        if ({panel_oe, panel_lat} !== 2'b11) begin
            n_fail++;
            $display("FAIL latch r%0d p%0d: oe=%0b lat=%0b, required 1 1", row, plane, panel_oe, panel_lat);
        end
        @(negedge clk);
        w = BASE_TICKS << plane;
        for (int k = 0; k < w; k++) begin
            n_checks++;
            if ({panel_oe, panel_lat, b_en} !== {(k < on) ? 1'b0 : 1'b1, 1'b0, 1'b0}) begin
                n_fail++;
                $display("FAIL display r%0d p%0d k%0d: oe=%0b lat=%0b en=%0b, required %0b 0 0",
                         row, plane, k, panel_oe, panel_lat, b_en, (k < on) ? 1'b0 : 1'b1);
            end
            @(negedge clk);
        end
        n_checks++;
        if ({panel_oe, frame_done} !== {1'b1, exp_done}) begin
            n_fail++;
            $display("FAIL after_display r%0d p%0d: oe=%0b frame_done=%0b, required 1 %0b",
                     row, plane, panel_oe, frame_done, exp_done);
        end
    endtask

    task automatic test_reset();
        rst    = 1'b1;
        enable = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++;
        if ({panel_oe, panel_lat, panel_clk, b_en, frame_done, b_addr, panel_a} !== {5'b10000, 4'd0, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_values: oe,lat,clk,en,done=%05b addr=%0d a=%0d, required 10000 0 0",
                     {panel_oe, panel_lat, panel_clk, b_en, frame_done}, b_addr, panel_a);
        end
        rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            n_checks++;
            if ({panel_oe, panel_lat, panel_clk, b_en, frame_done} !== 5'b10000) begin
                n_fail++;
                $display("FAIL idle_hold cyc%0d: oe,lat,clk,en,done=%05b, required 10000", i,
                         {panel_oe, panel_lat, panel_clk, b_en, frame_done});
            end
        end
    endtask

    task automatic test_frame_scan();
        enable = 1'b1;
        wait_b_en("start_scan");
        test_row_plane(0, 0, ON0, 1'b0);
        test_row_plane(0, 1, ON1, 1'b0);
        test_row_plane(1, 0, ON0, 1'b0);
        test_row_plane(1, 1, ON1, 1'b1);
    endtask

    // Starts on a frame_done cycle; the next pulse must be 84 cycles later.
    task automatic test_frame_period();
        int n, lows;
        bit seen;
        n = 0;
        lows = 0;
        seen = 1'b0;
        while (n < 200 && !seen) begin
            @(negedge clk);
            n++;
            if (panel_oe === 1'b0) lows++;
            if (frame_done === 1'b1) seen = 1'b1;
        end
        n_checks++;
        if (!seen || n != 84 || lows != LOWS) begin
            n_fail++;
            $display("FAIL frame_period: seen=%0b period=%0d oe_low=%0d, required 1 84 %0d", seen, n, lows, LOWS);
        end
    endtask

    task automatic test_enable_drop();
        int n;
        bit seen;
        repeat (50) @(negedge clk);
        enable = 1'b0;
        n = 50;
        seen = 1'b0;
        while (n < 150 && !seen) begin
            @(negedge clk);
            n++;
            if (frame_done === 1'b1) seen = 1'b1;
        end
        n_checks++;
        if (!seen || n != 84) begin
            n_fail++;
            $display("FAIL drop_enable_frame_end: seen=%0b at=%0d, required 1 84", seen, n);
        end
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            n_checks++;
            if ({panel_oe, b_en, frame_done, panel_lat, panel_clk} !== 5'b10000) begin
                n_fail++;
                $display("FAIL idle_after_drop cyc%0d: oe,en,done,lat,clk=%05b, required 10000", i,
                         {panel_oe, b_en, frame_done, panel_lat, panel_clk});
            end
        end
        enable = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({b_en, b_addr} !== {1'b1, 4'd0}) begin
            n_fail++;
            $display("FAIL reenable_addr: en=%0b addr=%0d, required 1 0", b_en, b_addr);
        end
    endtask

    task automatic test_reset_mid_display();
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            if (panel_oe === 1'b0) seen = 1'b1;
        end
        n_checks++;
        if (!seen) begin
            n_fail++;
            $display("FAIL reach_display: oe low seen=%0b, required 1", seen);
        end
        rst = 1'b1;
        #1;
        n_checks++;
        if ({panel_oe, b_en, panel_lat, panel_clk, frame_done} !== 5'b10000) begin
            n_fail++;
            $display("FAIL async_reset: oe,en,lat,clk,done=%05b, required 10000",
                     {panel_oe, b_en, panel_lat, panel_clk, frame_done});
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        wait_b_en("restart_after_reset");
        test_row_plane(0, 0, ON0, 1'b0);
        test_row_plane(0, 1, ON1, 1'b0);
    endtask

`ifdef LED_PANEL_SCANNER_BRIGHTNESS_EN
    task automatic test_brightness();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        brightness = 8'd128;
        wait_b_en("brightness_start");
        test_row_plane(0, 0, 1, 1'b0);
        test_row_plane(0, 1, 2, 1'b0);
        brightness = 8'd0;
        test_row_plane(1, 0, 0, 1'b0);
        test_row_plane(1, 1, 0, 1'b1);
        brightness = 8'd255;
    endtask
`endif

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst      = 1'b1;
        enable   = 1'b0;
`ifdef LED_PANEL_SCANNER_BRIGHTNESS_EN
        brightness = 8'd255;
`endif
        // Top half: R=01 at column 0 and assorted patterns elsewhere.
        mem[0]  = 32'h0000_0001;
        mem[1]  = 32'h0003_0201;
        mem[2]  = 32'h00FF_FFFF;
        mem[3]  = 32'hFF00_0000;
        mem[4]  = 32'h0001_0002;
        mem[5]  = 32'h0002_0100;
        mem[6]  = 32'h0000_0302;
        mem[7]  = 32'h0003_0003;
        // Bottom half: G=02 at column 0 and assorted patterns elsewhere.
        mem[8]  = 32'h0000_0200;
        mem[9]  = 32'h0000_0302;
        mem[10] = 32'h0000_0000;
        mem[11] = 32'h0001_0101;
        mem[12] = 32'h0002_0001;
        mem[13] = 32'h0001_0300;
        mem[14] = 32'h00FF_0000;
        mem[15] = 32'h0000_00FF;

        test_reset();
        test_frame_scan();
        test_frame_period();
        test_enable_drop();
        test_reset_mid_display();
`ifdef LED_PANEL_SCANNER_BRIGHTNESS_EN
        test_brightness();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
